dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache controller. It is the responder to the pipeline's MEM stage load/store requests and the initiator toward the 256-bit-line data memory. It stalls the pipeline on a miss, and only on a miss. Hits complete in the request cycle, so the MEM/WB register samples valid load data at the next clock edge.

---
 rtl/dcache_ctrl.sv | 133 +++++++++++++
 tb/tb_dcache_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete combinationally; misses stall through writeback/allocate/refill.
module dcache_ctrl #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILLED} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [255:0]       line_q [LINES];

  logic               line_we;
  logic [255:0]       line_d;
  logic [TAG_W-1:0]   tag_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [2:0]         word_sel;
  logic [7:0]         bit_off;
  logic [TAG_W-1:0]   cur_tag;
  logic [255:0]       cur_line;
  logic               hit;
  logic               unused_ok;

  assign idx       = cpu_addr_i[4+INDEX_W:5];
  assign req_tag   = cpu_addr_i[31:5+INDEX_W];
  assign word_sel  = cpu_addr_i[4:2];
  assign bit_off   = {word_sel, 5'b00000};
  assign cur_tag   = tag_q[idx];
  assign cur_line  = line_q[idx];
  assign hit       = cpu_req_i & valid_q[idx] & (cur_tag == req_tag);
  assign unused_ok = ^cpu_addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_we      = 1'b0;
    line_d       = cur_line;
    tag_d        = cur_tag;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) begin
              line_we               = 1'b1;
              line_d[bit_off +: 32] = cpu_data_i;
              dirty_d[idx]          = 1'b1;
            end else begin
              cpu_data_o = cur_line[bit_off +: 32];
            end
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {cur_tag, idx, 5'b00000};
        mem_data_o   = cur_line;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b00000};
        if (mem_ack_i) begin
          line_we      = 1'b1;
          line_d       = mem_data_i;
          tag_d        = req_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = REFILLED;
        end
      end
      REFILLED: begin
        // Gives the refilled line a cycle to be read back before the held request retires.
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents need no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (rst_i && line_we) begin
      line_q[idx] <= line_d;
      tag_q[idx]  <= tag_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a responding memory model and
// scoreboard queues for load data, writebacks and refill reads.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  typedef struct packed {
    logic [31:0]  a;
    logic [255:0] d;
  } wb_t;

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  ld_q[$];
  logic [31:0]  rd_q[$];
  wb_t          wb_q[$];
  logic [255:0] mem_m [logic [31:0]];

  dcache_ctrl #(.INDEX_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = a + 32'(w * 4) + 32'hA500_0000;
    return r;
  endfunction

  function automatic logic [255:0] getline(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : pat(a);
  endfunction

  // One CPU access, serving memory requests until the pipeline is released.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int wl, input int rl, input int exp_stall, input string tag);
    int   stall = 0;
    int   cnt = 0;
    logic pe = 1'b0, pw = 1'b0;
    bit   done = 0, gap = 0;
    wb_t  wb;
    logic [31:0] ra;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
    for (int i = 0; i < 200; i++) begin
      #1;
      mem_ack_i = 1'b0;
      if (!cpu_stall_o) begin
        done = 1;
        chk({tag, "_hit_no_mem"}, mem_enable_o, 1'b0);
        if (!we) begin
          if (ld_q.size() == 0) chk({tag, "_ld_q_empty"}, 1'b1, 1'b0);
          else chk({tag, "_load"}, cpu_data_o, ld_q.pop_front());
        end
        break;
      end
      stall++;
      if (pe && pw && !mem_enable_o) gap = 1;
      if (mem_enable_o) begin
        if (!pe || pw != mem_write_o) cnt = 0;
        cnt++;
        if (cnt == (mem_write_o ? wl : rl)) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) begin
            if (wb_q.size() == 0) chk({tag, "_unexpected_wb"}, mem_addr_o, 32'hFFFF_FFFF);
            else begin
              wb = wb_q.pop_front();
              chk({tag, "_wb_addr"}, mem_addr_o, wb.a);
              chk({tag, "_wb_data"}, mem_data_o, wb.d);
            end
            mem_m[mem_addr_o] = mem_data_o;
          end else begin
            if (rd_q.size() == 0) chk({tag, "_unexpected_rd"}, mem_addr_o, 32'hFFFF_FFFF);
            else begin
              ra = rd_q.pop_front();
              chk({tag, "_rd_addr"}, mem_addr_o, ra);
            end
            mem_data_i = getline(mem_addr_o);
          end
        end
      end
      pe = mem_enable_o; pw = mem_write_o;
      @(negedge clk_i);
    end
    if (!done) chk({tag, "_timeout"}, 1'b1, 1'b0);
    chk({tag, "_stall_cycles"}, 32'(stall), 32'(exp_stall));
    chk({tag, "_enable_gap"}, gap, 1'b0);
  endtask

  initial begin
    logic [255:0] l;
    bit seen;

    // Reset with no request held.
    @(negedge clk_i); @(negedge clk_i);
    #1;
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_data", cpu_data_o, 32'h0);
    chk("rst_en", mem_enable_o, 1'b0);
    chk("rst_wr", mem_write_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_mdata", mem_data_o, 256'h0);
    rst_i = 1'b1;

    // Clean miss, read ack in the third enabled cycle.
    l = pat(32'h400); l[31:0] = 32'hDEAD_BEEF; mem_m[32'h400] = l;
    rd_q.push_back(32'h400);
    ld_q.push_back(32'hDEAD_BEEF);
    access(1'b0, 32'h400, 32'h0, 1, 3, 5, "clean_miss");

    // Store hit then load hit.
    access(1'b1, 32'h404, 32'h1234_5678, 1, 1, 0, "store_hit");
    ld_q.push_back(32'h1234_5678);
    access(1'b0, 32'h404, 32'h0, 1, 1, 0, "load_hit");

    // Dirty conflict on index 0.
    l = mem_m[32'h400]; l[63:32] = 32'h1234_5678;
    wb_q.push_back('{a: 32'h400, d: l});
    rd_q.push_back(32'h800);
    ld_q.push_back(pat(32'h800) >> 0 & 256'hFFFF_FFFF);
    access(1'b0, 32'h800, 32'h0, 2, 3, 7, "dirty_miss");

    // Store miss: allocate then merge into word 2.
    rd_q.push_back(32'hC00);
    access(1'b1, 32'hC08, 32'hCAFE_F00D, 1, 2, 4, "store_miss");
    ld_q.push_back(32'hCAFE_F00D);
    access(1'b0, 32'hC08, 32'h0, 1, 1, 0, "store_miss_word2");
    l = pat(32'hC00);
    ld_q.push_back(l[31:0]);
    access(1'b0, 32'hC00, 32'h0, 1, 1, 0, "store_miss_word0");

    // Evicting the merged line; 0x404 comes back from memory.
    l = pat(32'hC00); l[95:64] = 32'hCAFE_F00D;
    wb_q.push_back('{a: 32'hC00, d: l});
    rd_q.push_back(32'h400);
    ld_q.push_back(32'h1234_5678);
    access(1'b0, 32'h404, 32'h0, 3, 2, 7, "evict_merged");

    // Make 0x800 valid again, then reset in the middle of an allocate.
    rd_q.push_back(32'h800);
    l = getline(32'h800);
    ld_q.push_back(l[31:0]);
    access(1'b0, 32'h800, 32'h0, 1, 2, 4, "reload_800");
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hC00;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_enable_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    chk("alloc_started", seen, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0; cpu_req_i = 1'b0;
    @(negedge clk_i); #1;
    chk("midrst_en", mem_enable_o, 1'b0);
    chk("midrst_stall", cpu_stall_o, 1'b0);
    chk("midrst_addr", mem_addr_o, 32'h0);
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_en", mem_enable_o, 1'b0);
    chk("late_ack_stall", cpu_stall_o, 1'b0);
    rd_q.push_back(32'h800);
    l = getline(32'h800);
    ld_q.push_back(l[31:0]);
    access(1'b0, 32'h800, 32'h0, 1, 2, 4, "post_rst_miss");

    // No request: random address/data must cause nothing.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      cpu_req_i = 1'b0; cpu_we_i = 1'($urandom_range(0, 1));
      cpu_addr_i = $urandom; cpu_data_i = $urandom;
      #1;
      chk("idle_quiet", {cpu_stall_o, mem_enable_o, mem_write_o, cpu_data_o, mem_addr_o}, '0);
    end
    chk("queues_drained", 32'(ld_q.size() + rd_q.size() + wb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
